// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the bit-serial ALU sequencer.
package alu_pkg;

    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_supported(input logic [OP_W-1:0] o);
        return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) ||
               (o == OP_SUB) || (o == OP_SLT);
    endfunction

    // SUB and SLT run the adder as a + ~b + 1.
    function automatic logic op_inverts(input logic [OP_W-1:0] o);
        return (o == OP_SUB) || (o == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND, OR or full add, selected by the low opcode bits.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
        case (op)
            2'b00:   s = a & b;
            2'b01:   s = a | b;
            default: s = a ^ b ^ cin;
        endcase
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU controller: one operand bit per cycle through alu_bit_slice,
// LSB first, with MSB overflow/SLT resolution on the final bit.
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             op_err
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-2:0]   sr_q;
    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;
    logic               zero_q;
    logic               op_err_q;

    logic               inv_c;
    logic               s_c;
    logic               cout_c;
    logic               last_c;
    logic               ovf_c;
    logic               lt_c;
    logic [WIDTH-1:0]   full_c;
    logic [WIDTH-1:0]   res_c;

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign op_err   = op_err_q;

    alu_bit_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0] ^ inv_c),
        .cin  (carry_q),
        .op   (op_q[1:0]),
        .s    (s_c),
        .cout (cout_c)
    );

    // Final-bit resolution: sa/sb are the captured operand MSBs, s_c is the result MSB.
    always_comb begin
        inv_c  = op_inverts(op_q);
        full_c = {s_c, sr_q};
        last_c = (cnt_q == CNT_W'(WIDTH - 1));
        ovf_c  = 1'b0;
        if (op_q == OP_ADD) begin
            ovf_c = (sa_q == sb_q) && (s_c != sa_q);
        end else if (inv_c) begin
            ovf_c = (sa_q != sb_q) && (s_c != sa_q);
        end
        lt_c  = s_c ^ ovf_c;
        res_c = (op_q == OP_SLT) ? WIDTH'(lt_c) : full_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sr_q       <= '0;
            op_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (start) begin
                        overflow_q <= 1'b0;
                        zero_q     <= 1'b0;
                        op_err_q   <= 1'b0;
                        if (op_supported(op)) begin
                            a_q     <= a;
                            b_q     <= b;
                            op_q    <= op;
                            sa_q    <= a[WIDTH-1];
                            sb_q    <= b[WIDTH-1];
                            cnt_q   <= '0;
                            carry_q <= op_inverts(op);
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            // Unsupported opcode completes immediately with an error.
                            result_q <= '0;
                            zero_q   <= 1'b1;
                            op_err_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sr_q    <= full_c[WIDTH-1:1];
                    carry_q <= cout_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        result_q   <= res_c;
                        overflow_q <= (op_q == OP_SLT) ? 1'b0 : ovf_c;
                        zero_q     <= (res_c == '0);
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer (WIDTH=8): directed vectors
// with literal expectations plus a per-cycle comparison against an arithmetic model.
module tb_alu_serial_sequencer;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;
    logic         op_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] res;
        logic         ov;
        logic         er;
    } exp_t;

    // Reference arithmetic on signed integers, independent of any bit-serial detail.
    function automatic exp_t golden(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   ix;
        int   iy;
        int   s;
        int   hi;
        int   lo;
        ix = $signed(x);
        iy = $signed(y);
        hi = (1 << (W - 1)) - 1;
        lo = -(1 << (W - 1));
        e  = '0;
        case (f)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin s = ix + iy; e.res = W'(s); e.ov = (s > hi) || (s < lo); end
            3'b110: begin s = ix - iy; e.res = W'(s); e.ov = (s > hi) || (s < lo); end
            3'b111: e.res = (ix < iy) ? W'(1) : W'(0);
            default: e.er = 1'b1;
        endcase
        return e;
    endfunction

    exp_t         g;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_zero  = 1'b0;
    logic         m_err   = 1'b0;
    logic [W-1:0] m_res   = '0;
    int           m_left  = 0;
    logic [W-1:0] p_res   = '0;
    logic         p_ovf   = 1'b0;

    always_comb g = golden(op, a, b);

    // Transaction-level timing model: busy for W cycles, then a one-cycle done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
            m_err  <= 1'b0;
            m_res  <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_ovf  <= p_ovf;
                    m_zero <= (p_res == '0);
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start) begin
                m_ovf  <= 1'b0;
                m_zero <= 1'b0;
                m_err  <= 1'b0;
                if (g.er) begin
                    m_done <= 1'b1;
                    m_res  <= '0;
                    m_zero <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= int'(W);
                    p_res  <= g.res;
                    p_ovf  <= g.ov;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc busy", 32'(busy), 32'(m_busy));
        check("cyc done", 32'(done), 32'(m_done));
        check("cyc overflow", 32'(overflow), 32'(m_ovf));
        check("cyc zero", 32'(zero), 32'(m_zero));
        check("cyc op_err", 32'(op_err), 32'(m_err));
        if (!m_busy) check("cyc result", 32'(result), 32'(m_res));
    end

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    // Called at a negedge; issues one op and checks literal results at done.
    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eres, input logic eov,
                          input logic ez, input logic eerr, input int elat);
        int k;
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        check({name, " busy"}, 32'(busy), 32'(elat > 0));
        wait_done(k);
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " latency"}, 32'(k), 32'(elat));
        check({name, " result"}, 32'(result), 32'(eres));
        check({name, " overflow"}, 32'(overflow), 32'(eov));
        check({name, " zero"}, 32'(zero), 32'(ez));
        check({name, " op_err"}, 32'(op_err), 32'(eerr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'({overflow, zero, op_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ovf",  3'b010, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 8);
        run_op("sub_ovf",  3'b110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 8);
        repeat (2) @(negedge clk);
        run_op("sub_zero", 3'b110, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8);
        run_op("slt_neg",  3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8);
        run_op("slt_pos",  3'b111, 8'h03, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8);
        run_op("and",      3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 8);
        run_op("or",       3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 8);
        run_op("bad_op",   3'b011, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b1, 0);
        run_op("add_wrap", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8);
        run_op("sub_neg",  3'b110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 8);
        repeat (2) @(negedge clk);

        // Start pulsed mid-run must be ignored.
        start = 1'b1; op = 3'b010; a = 8'h11; b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check("ignore busy", 32'(busy), 32'd1);
        wait_done(k);
        check("ignore done", 32'(done), 32'd1);
        check("ignore result", 32'(result), 32'h33);
        run_op("sub_from_done", 3'b110, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 8);
        repeat (2) @(negedge clk);

        // Asynchronous reset at cnt=4 aborts the op without a done pulse.
        start = 1'b1; op = 3'b010; a = 8'h01; b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort flags", 32'({overflow, zero, op_err}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort no done", 32'(done), 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op("add_after_rst", 3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 8);
        repeat (12) @(negedge clk);
        check("final idle done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
